// File: rtl/pixie_scan_engine.sv
// pixie_scan_engine
//   PIXIE-class raster back end. A free-running pixel counter (hcnt) and a line
//   counter (vcnt) produce the timing. On active lines, one frame-buffer byte is
//   fetched per 8 pixels and shifted out MSB first on 'video'.
//
//   Display enable and line replication are latched once per frame, in the
//   hcnt=0/vcnt=0 cycle, so a frame is never torn by a mid-frame change. Sync
//   timing is independent of both.
//
// Ports
//   clk, reset_n         pixel clock, synchronous active-low reset
//   disp_en, line_rep    display enable / vertical replication (0..3 = 1x..8x)
//   fb_read_en, fb_addr  frame-buffer read strobe and {row, byte} address
//   fb_data              read data, valid the cycle after fb_read_en
//   hsync, vsync, csync  syncs, active high (csync = hsync ^ vsync)
//   hblank, vblank       blanking windows
//   video                pixel out, 1 = lit
//   frame_int, efx       frame interrupt pulse and EFX status
module pixie_scan_engine #(
    parameter int PIXELS_PER_LINE = 112,
    parameter int BYTES_PER_ROW   = 8,
    parameter int HSYNC_START     = 82,
    parameter int HSYNC_WIDTH     = 12,
    parameter int LINES_PER_FRAME = 262,
    parameter int ACTIVE_V_LINES  = 128,
    parameter int VSYNC_START     = 182,
    parameter int VSYNC_HEIGHT    = 16,
    parameter int ADDR_W          = 10,
    parameter int LEAD_LINES      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_en,
    input  logic [1:0]        line_rep,
    output logic              fb_read_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              hsync,
    output logic              vsync,
    output logic              csync,
    output logic              hblank,
    output logic              vblank,
    output logic              video,
    output logic              frame_int,
    output logic              efx
);

    localparam int HW      = $clog2(PIXELS_PER_LINE);
    localparam int VW      = $clog2(LINES_PER_FRAME);
    localparam int BW      = $clog2(BYTES_PER_ROW);
    localparam int RW      = ADDR_W - BW;
    localparam int ACT_W   = 8 * BYTES_PER_ROW;
    localparam int INT_LN  = LINES_PER_FRAME - LEAD_LINES;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          disp_on;
    logic [1:0]    rep;
    logic [7:0]    shreg;
    logic          fetch_d;
    logic          hsync_q, vsync_q, hblank_q, vblank_q, video_q, fint_q, efx_q;

    logic          h_last, line_act, fetch, vid_win;
    logic [BW-1:0] byte_idx;
    logic [RW-1:0] row;

    assign h_last   = (int'(hcnt) == PIXELS_PER_LINE - 1);
    assign line_act = (int'(vcnt) < ACTIVE_V_LINES);
    assign byte_idx = BW'(hcnt >> 3);
    // Row wraps modulo the row field when the replicated line count exceeds it.
    assign row      = RW'(vcnt >> rep);

    // Fetch cycle of byte b is hcnt = 8b+1.
    assign fetch    = disp_on && line_act && (hcnt[2:0] == 3'd1) &&
                      (int'(hcnt >> 3) < BYTES_PER_ROW);

    // Cycles whose *next* cycle lies in the visible window [4, 4+8*BPR).
    // Registered outputs decoded here line up exactly with that window.
    assign vid_win  = (int'(hcnt) >= 3) && (int'(hcnt) < 3 + ACT_W);

    assign fb_read_en = fetch;
    assign fb_addr    = fetch ? {row, byte_idx} : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            disp_on  <= 1'b0;
            rep      <= 2'd0;
            shreg    <= 8'h00;
            fetch_d  <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            video_q  <= 1'b0;
            fint_q   <= 1'b0;
            efx_q    <= 1'b0;
        end else begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= (int'(vcnt) == LINES_PER_FRAME - 1) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end

            // Frame start: latch per-frame controls.
            if (hcnt == '0 && vcnt == '0) begin
                disp_on <= disp_en;
                rep     <= line_rep;
            end

            // Data returns one cycle after the strobe; load wins over shift.
            fetch_d <= fetch;
            if (fetch_d)
                shreg <= fb_data;
            else if (vid_win)
                shreg <= {shreg[6:0], 1'b0};

            video_q  <= vid_win && line_act && disp_on && shreg[7];
            hblank_q <= !vid_win;
            hsync_q  <= (int'(hcnt) >= HSYNC_START) &&
                        (int'(hcnt) <  HSYNC_START + HSYNC_WIDTH);

            // Line decodes are taken at hcnt=0 so they change at hcnt=1.
            if (hcnt == '0) begin
                vsync_q  <= (int'(vcnt) >= VSYNC_START) &&
                            (int'(vcnt) <  VSYNC_START + VSYNC_HEIGHT);
                vblank_q <= !line_act;
                efx_q    <= (int'(vcnt) >= INT_LN) ||
                            ((int'(vcnt) >= ACTIVE_V_LINES - LEAD_LINES) && line_act);
            end

            fint_q <= (hcnt == '0) && (int'(vcnt) == INT_LN) && disp_en;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign csync     = hsync_q ^ vsync_q;
    assign hblank    = hblank_q;
    assign vblank    = vblank_q;
    assign video     = video_q;
    assign frame_int = fint_q;
    assign efx       = efx_q;

endmodule

// File: tb/tb_pixie_scan_engine.sv
// Bench for pixie_scan_engine: a cycle-position reference (line/pixel derived
// from elapsed cycles with plain arithmetic) predicts every output each cycle,
// plus frame-level statistics and directed spot checks.
module tb_pixie_scan_engine;
    localparam int PPL = 112, LPF = 262, AV = 128, BPR = 8;
    localparam int FRAME = PPL * LPF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       disp_en = 1'b1;
    logic [1:0] line_rep = 2'd0;
    logic       fb_read_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic       hsync, vsync, csync, hblank, vblank, video, frame_int, efx;

    pixie_scan_engine dut (
        .clk(clk), .reset_n(reset_n), .disp_en(disp_en), .line_rep(line_rep),
        .fb_read_en(fb_read_en), .fb_addr(fb_addr), .fb_data(fb_data),
        .hsync(hsync), .vsync(vsync), .csync(csync), .hblank(hblank),
        .vblank(vblank), .video(video), .frame_int(frame_int), .efx(efx)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    always @(posedge clk) if (fb_read_en) fb_data <= mem[fb_addr];

    int  compared = 0, mismatched = 0;
    int  t = 0;                       // cycles since the post-reset hcnt=0,vcnt=0 cycle
    bit  m_don = 0, m_de = 0;
    int  m_rep = 0;
    bit  stats = 0;
    int  hs_cnt[3], fi_cnt[3], rd_cnt[3];
    int  vs_rise[$];
    bit  prev_hs = 0, prev_vs = 0;
    logic [8:0] l0_vid;
    logic [9:0] a_l4, a_l127;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [2:0] line_bits(input int v);  // {efx, vblank, vsync}
        line_bits[0] = (v >= 182 && v < 198);
        line_bits[1] = (v >= AV);
        line_bits[2] = (v >= LPF - 4) || (v >= AV - 4 && v < AV);
    endfunction

    task automatic step();
        int h, v, fi, idx;
        logic [7:0] b;
        logic [2:0] lb;
        logic e_rd, e_vid, e_hb, e_hs, e_fi;
        logic [8:0] obs, exp;
        @(posedge clk);
        if (!reset_n) begin
            t = 0; m_don = 0; m_rep = 0; m_de = 0;
        end else begin
            if (t % FRAME == 0) begin m_don = disp_en; m_rep = line_rep; end
            m_de = disp_en;
            t++;
        end
        #1;
        h = t % PPL; v = (t / PPL) % LPF; fi = t / FRAME;
        e_rd = m_don && v < AV && (h % 8 == 1) && (h / 8 < BPR);
        e_vid = 0;
        if (t > 0 && m_don && v < AV && h >= 4 && h < 4 + 8 * BPR) begin
            idx = ((v >> m_rep) % 128) * 8 + (h - 4) / 8;
            b = mem[idx];
            e_vid = b[7 - (h - 4) % 8];
        end
        e_hb = (t > 0) && !(h >= 4 && h < 4 + 8 * BPR);
        e_hs = (t > 0) && h >= 83 && h <= 94;
        lb = (t == 0) ? 3'b000 : line_bits(h == 0 ? (v + LPF - 1) % LPF : v);
        e_fi = (t > 0) && h == 1 && v == LPF - 4 && m_de;
        exp = {e_rd, e_hs, lb[0], e_hs ^ lb[0], e_hb, lb[1], e_vid, e_fi, lb[2]};
        obs = {fb_read_en, hsync, vsync, csync, hblank, vblank, video, frame_int, efx};
        check("outputs", {23'd0, obs}, {23'd0, exp});
        if (e_rd)
            check("fb_addr", {22'd0, fb_addr}, ((v >> m_rep) % 128) * 8 + h / 8);
        if (stats && fi < 3) begin
            if (hsync && !prev_hs) hs_cnt[fi]++;
            if (vsync && !prev_vs) vs_rise.push_back(t);
            if (frame_int) fi_cnt[fi]++;
            if (fb_read_en) rd_cnt[fi]++;
            if (fi == 0 && v == 0 && h >= 3 && h <= 11) l0_vid[11 - h] = video;
            if (fi == 0 && v == 0 && h == 68) check("video_h68", {31'd0, video}, 0);
            if (fi == 1 && v == 4 && h == 1) a_l4 = fb_addr;
            if (fi == 1 && v == 127 && h == 57) a_l127 = fb_addr;
        end
        prev_hs = hsync; prev_vs = vsync;
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;
        for (int i = 0; i < 3; i++) begin hs_cnt[i] = 0; fi_cnt[i] = 0; rd_cnt[i] = 0; end
        r0 = $urandom_range(0, 2);
        if (r0 == 2) r0 = 3;          // initial replication from {1x, 2x, 8x}

        // Power-on reset, then run into line 3 with display on.
        reset_n = 0; disp_en = 1; line_rep = 2'(r0);
        repeat (5) step();
        reset_n = 1;
        while (t < 3 * PPL + 17) step();
        check("fetch_before_reset", {31'd0, fb_read_en}, 1);

        // Reset lands on a fetch cycle and is held 10 cycles mid-frame.
        reset_n = 0;
        repeat (10) step();
        check("rst_outs_zero", {22'd0, fb_read_en, hsync, vsync, csync, hblank,
                                vblank, video, frame_int, efx, 1'b0}, 0);
        reset_n = 1;
        stats = 1;
        step();
        check("first_fetch", {31'd0, fb_read_en}, 1);
        check("first_addr", {22'd0, fb_addr}, 0);

        // Frame 0: replication change mid-frame takes effect next frame.
        while (t < 50 * PPL) step();
        line_rep = 2'd2;
        // Frame 1: display disabled mid-frame; frame 2 must be dark.
        while (t < FRAME + 50 * PPL) step();
        disp_en = 0;
        while (t < 2 * FRAME + 20 * PPL) step();

        check("l0_video_A5", {23'd0, l0_vid}, 9'b0_1010_0101);
        check("hsync_pulses_f0", hs_cnt[0], LPF);
        check("hsync_pulses_f1", hs_cnt[1], LPF);
        if (vs_rise.size() >= 2)
            check("frame_period", vs_rise[1] - vs_rise[0], FRAME);
        else
            check("vsync_rises", vs_rise.size(), 2);
        check("frame_int_f0", fi_cnt[0], 1);
        check("frame_int_f1", fi_cnt[1], 0);
        check("reads_f0", rd_cnt[0], AV * BPR);
        check("reads_f1", rd_cnt[1], AV * BPR);
        check("reads_f2", rd_cnt[2], 0);
        check("rep4_line4_addr", {22'd0, a_l4}, 8);
        check("rep4_line127_addr", {22'd0, a_l127}, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
